// File: rtl/fetch_queue_stage_if.sv
// rtl/fetch_queue_stage_if.sv - redirect, imem and decode-side signals of the fetch queue stage
interface fetch_queue_stage_if #(
    parameter int ADDR_W = 32,
    parameter int ILEN   = 32
);
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              imem_read;
    logic [ADDR_W-1:0] imem_address;
    logic              imem_resp;
    logic [ILEN-1:0]   imem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_pc;
    logic [ILEN-1:0]   out_instr;
    logic [ADDR_W-1:0] out_pc_next;

    // The fetch stage itself: drives the imem request and the decode-facing head
    modport master (
        input  redirect_valid, redirect_pc, imem_resp, imem_rdata, out_ready,
        output imem_read, imem_address, out_valid, out_pc, out_instr, out_pc_next
    );

    // Environment: memory, decode and branch resolution
    modport slave (
        output redirect_valid, redirect_pc, imem_resp, imem_rdata, out_ready,
        input  imem_read, imem_address, out_valid, out_pc, out_instr, out_pc_next
    );
endinterface

// File: rtl/fetch_queue_stage.sv
// rtl/fetch_queue_stage.sv - instruction fetch with DEPTH-entry queue and stale-response drain
module fetch_queue_stage #(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 32,
    parameter int                ILEN     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h4000_0000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    fetch_queue_stage_if.master        bus,
    output logic [$clog2(DEPTH+1)-1:0] fq_count
);
    localparam int             PW   = $clog2(DEPTH);
    localparam int             CW   = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]  FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] fpc;
    logic [ADDR_W-1:0] stale_addr;

    logic [ADDR_W-1:0] pc_mem    [DEPTH];
    logic [ILEN-1:0]   instr_mem [DEPTH];
    logic [ADDR_W-1:0] pcn_mem   [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_next;
    logic              out_valid_q;

    logic redirect;
    logic complete;
    logic push;
    logic pop;

    assign redirect         = bus.redirect_valid;
    assign bus.imem_read    = (state == FETCH) || (state == DRAIN);
    assign bus.imem_address = (state == DRAIN) ? stale_addr : fpc;
    assign complete         = bus.imem_read && bus.imem_resp;
    // A redirect squashes both the incoming word and any decode handshake
    assign push             = (state == FETCH) && complete && !redirect;
    assign pop              = out_valid_q && bus.out_ready && !redirect;

    // Occupancy after this edge; a redirect empties the queue outright
    always_comb begin
        count_next = count;
        if (redirect) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    // Request sequencing: launch, back-to-back fetch, and draining the abandoned request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            fpc        <= RESET_PC;
            stale_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect) begin
                        fpc   <= bus.redirect_pc;
                        state <= FETCH;
                    end else if (count < FULL) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (redirect) begin
                        fpc <= bus.redirect_pc;
                        if (!bus.imem_resp) begin
                            stale_addr <= fpc;
                            state      <= DRAIN;
                        end
                    end else if (bus.imem_resp) begin
                        fpc <= fpc + ADDR_W'(4);
                        if (count_next == FULL) begin
                            state <= IDLE;
                        end
                    end
                end
                DRAIN: begin
                    if (redirect) begin
                        fpc <= bus.redirect_pc;
                    end
                    if (bus.imem_resp) begin
                        state <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Queue pointers, occupancy and the registered head-valid flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
            end
            count       <= count_next;
            out_valid_q <= (count_next != '0);
        end
    end

    // Entry storage needs no reset: nothing is visible until count says so
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= fpc;
            instr_mem[wr_ptr] <= bus.imem_rdata;
            pcn_mem[wr_ptr]   <= fpc + ADDR_W'(4);
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_pc      = out_valid_q ? pc_mem[rd_ptr]    : '0;
    assign bus.out_instr   = out_valid_q ? instr_mem[rd_ptr] : '0;
    assign bus.out_pc_next = out_valid_q ? pcn_mem[rd_ptr]   : '0;
    assign fq_count        = count;
endmodule

// File: tb/tb_fetch_queue_stage.sv
// tb/tb_fetch_queue_stage.sv - self-checking bench for fetch_queue_stage
module tb_fetch_queue_stage;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h4000_0000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] fq_count;

    always #5 clk = ~clk;

    fetch_queue_stage_if #(.ADDR_W(32), .ILEN(32)) bus ();

    fetch_queue_stage #(
        .DEPTH(DEPTH), .ADDR_W(32), .ILEN(32), .RESET_PC(RPC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .fq_count(fq_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of fetched entries plus the one request in flight
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pcn;
    } ent_t;

    ent_t        mq[$];
    bit          m_act;
    bit          m_stale;
    logic [31:0] m_addr;
    logic [31:0] m_tgt;

    function automatic void model_reset();
        mq.delete();
        m_act   = 1'b0;
        m_stale = 1'b0;
        m_addr  = RPC;
        m_tgt   = RPC;
    endfunction

    function automatic void model_step(input bit rv, input logic [31:0] rpc, input bit resp,
                                       input logic [31:0] rdata, input bit rdy);
        bit   comp;
        bit   vld;
        int   pre;
        ent_t e;
        comp = m_act && resp;
        vld  = (mq.size() != 0);
        pre  = mq.size();
        if (rv) begin
            mq.delete();
            if (m_act && !comp) begin
                m_stale = 1'b1;
                m_tgt   = rpc;
            end else begin
                m_act   = 1'b1;
                m_stale = 1'b0;
                m_addr  = rpc;
            end
        end else begin
            if (vld && rdy) void'(mq.pop_front());
            if (comp) begin
                if (m_stale) begin
                    m_stale = 1'b0;
                    m_addr  = m_tgt;
                end else begin
                    e.pc    = m_addr;
                    e.instr = rdata;
                    e.pcn   = m_addr + 32'd4;
                    mq.push_back(e);
                    m_addr = m_addr + 32'd4;
                    if (mq.size() == DEPTH) m_act = 1'b0;
                end
            end else if (!m_act && pre < DEPTH) begin
                m_act = 1'b1;
            end
        end
    endfunction

    task automatic check_model();
        ent_t h;
        h = (mq.size() != 0) ? mq[0] : '0;
        chk("imem_read", 64'(bus.imem_read), 64'(m_act));
        if (m_act) chk("imem_address", 64'(bus.imem_address), 64'(m_addr));
        chk("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
        chk("out_pc", 64'(bus.out_pc), 64'(h.pc));
        chk("out_instr", 64'(bus.out_instr), 64'(h.instr));
        chk("out_pc_next", 64'(bus.out_pc_next), 64'(h.pcn));
        chk("fq_count", 64'(fq_count), 64'(mq.size()));
    endtask

    task automatic drive(input bit rv, input logic [31:0] rpc, input bit resp,
                         input logic [31:0] rdata, input bit rdy);
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.imem_resp      = resp;
        bus.imem_rdata     = rdata;
        bus.out_ready      = rdy;
        #1;
    endtask

    // Called at negedge+1 after drive(): compare, clock once, update the model
    task automatic advance();
        check_model();
        @(posedge clk);
        model_step(bus.redirect_valid, bus.redirect_pc, bus.imem_resp, bus.imem_rdata, bus.out_ready);
        @(negedge clk);
    endtask

    task automatic cycle(input bit rv, input logic [31:0] rpc, input bit resp,
                         input logic [31:0] rdata, input bit rdy);
        drive(rv, rpc, resp, rdata, rdy);
        advance();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset imem_read", 64'(bus.imem_read), 64'd0);
        chk("reset out_valid", 64'(bus.out_valid), 64'd0);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit          rv;
        logic [31:0] rpc;
        bit          resp;
        logic [31:0] rdata;
        bit          rdy;
        bit          e_read;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
        int          e_cnt;
    } vec_t;

    vec_t vt[6];

    initial begin
        // Streaming with resp tied high and decode always ready
        vt[0] = '{0, 32'h0, 1, 32'hA000_0000, 1, 0, 32'h0,         0, 32'h0,         0};
        vt[1] = '{0, 32'h0, 1, 32'hA000_0001, 1, 1, 32'h4000_0000, 0, 32'h0,         0};
        vt[2] = '{0, 32'h0, 1, 32'hA000_0002, 1, 1, 32'h4000_0004, 1, 32'h4000_0000, 1};
        vt[3] = '{0, 32'h0, 1, 32'hA000_0003, 1, 1, 32'h4000_0008, 1, 32'h4000_0004, 1};
        vt[4] = '{0, 32'h0, 1, 32'hA000_0004, 1, 1, 32'h4000_000C, 1, 32'h4000_0008, 1};
        vt[5] = '{0, 32'h0, 1, 32'hA000_0005, 1, 1, 32'h4000_0010, 1, 32'h4000_000C, 1};

        @(negedge clk);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(vt[i].rv, vt[i].rpc, vt[i].resp, vt[i].rdata, vt[i].rdy);
            chk("vec imem_read", 64'(bus.imem_read), 64'(vt[i].e_read));
            if (vt[i].e_read) chk("vec imem_address", 64'(bus.imem_address), 64'(vt[i].e_addr));
            chk("vec out_valid", 64'(bus.out_valid), 64'(vt[i].e_valid));
            chk("vec out_pc", 64'(bus.out_pc), 64'(vt[i].e_pc));
            if (vt[i].e_valid) chk("vec out_pc_next", 64'(bus.out_pc_next), 64'(vt[i].e_pc + 32'd4));
            chk("vec fq_count", 64'(fq_count), 64'(vt[i].e_cnt));
            advance();
        end
        // Push+pop at count=1 keeps occupancy steady across pointer wraps
        for (int i = 0; i < 2 * DEPTH; i++) begin
            cycle(1'b0, 32'h0, 1'b1, $urandom, 1'b1);
            chk("pp1 fq_count", 64'(fq_count), 64'd1);
        end

        // Fill with decode stalled, then release one pop
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b1, $urandom, 1'b0);
        chk("full fq_count", 64'(fq_count), 64'd4);
        chk("full imem_read", 64'(bus.imem_read), 64'd0);
        cycle(1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
        for (int i = 0; i < 5 && !bus.imem_read; i++) cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("refetch imem_read", 64'(bus.imem_read), 64'd1);
        chk("refetch imem_address", 64'(bus.imem_address), 64'h4000_0010);

        // Redirect with request outstanding: stale response dropped
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, $urandom, 1'b1);
        chk("pre-redir address", 64'(bus.imem_address), 64'h4000_0008);
        cycle(1'b1, 32'h4000_0100, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("drain address", 64'(bus.imem_address), 64'h4000_0008);
            chk("drain out_valid", 64'(bus.out_valid), 64'd0);
            cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        end
        cycle(1'b0, 32'h0, 1'b1, 32'h0BAD_0BAD, 1'b1);
        chk("post-drain address", 64'(bus.imem_address), 64'h4000_0100);
        chk("post-drain out_valid", 64'(bus.out_valid), 64'd0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, $urandom, 1'b1);

        // Redirect coincident with completion and pop at count=3
        do_reset();
        for (int i = 0; i < 8 && fq_count != 3; i++) cycle(1'b0, 32'h0, 1'b1, $urandom, 1'b0);
        chk("count3 reached", 64'(fq_count), 64'd3);
        cycle(1'b1, 32'h4000_0200, 1'b1, 32'hDEAD_BEEF, 1'b1);
        chk("redir fq_count", 64'(fq_count), 64'd0);
        chk("redir out_valid", 64'(bus.out_valid), 64'd0);
        chk("redir imem_address", 64'(bus.imem_address), 64'h4000_0200);
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, $urandom, 1'b1);

        // Push+pop at count=DEPTH-1
        do_reset();
        for (int i = 0; i < 8 && fq_count != 3; i++) cycle(1'b0, 32'h0, 1'b1, $urandom, 1'b0);
        for (int i = 0; i < 2 * DEPTH; i++) begin
            cycle(1'b0, 32'h0, 1'b1, $urandom, 1'b1);
            chk("pp3 fq_count", 64'(fq_count), 64'd3);
        end

        // Asynchronous reset while draining
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, $urandom, 1'b0);
        cycle(1'b1, 32'h4000_0300, 1'b0, 32'h0, 1'b0);
        chk("in drain imem_read", 64'(bus.imem_read), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async imem_read", 64'(bus.imem_read), 64'd0);
        chk("async out_valid", 64'(bus.out_valid), 64'd0);
        chk("async fq_count", 64'(fq_count), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 32'h0, 1'b1, $urandom, 1'b1);
        chk("restart address", 64'(bus.imem_address), 64'h4000_0000);
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, $urandom, 1'b1);

        // Randomised traffic against the model, including wrap-around targets
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            cycle($urandom_range(0, 19) == 0, rpc, $urandom_range(0, 9) < 6,
                  $urandom, $urandom_range(0, 9) < 6);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
